// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: concatenates 1..CODE_W-bit codewords MSB-first into bytes,
// with a flush that zero-pads and tags the final partial byte.
module huffman_bit_packer #(
  parameter int unsigned CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code_bits,
  input  logic [3:0]        code_len,
  input  logic              flush,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              byte_last,
  output logic              flush_done,
  output logic [3:0]        fill_level
);

  localparam int unsigned ACC_W  = 15;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] MAX_LEN   = CNT_W'(CODE_W);
  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(BYTE_W);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [CNT_W-1:0]   len_eff;
  logic [BYTE_W-1:0]  code_ext;
  logic [BYTE_W-1:0]  code_mask;
  logic [BYTE_W-1:0]  code_m;
  logic [CNT_W-1:0]   shamt;
  logic [ACC_W-1:0]   ins;
  logic [ACC_W-1:0]   acc_app;
  logic [CNT_W:0]     cnt_sum;
  logic               accept;
  logic               slot_free;
  logic               extract;
  logic               flush_exit;
  logic               pad_load;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_next;

  assign code_ready = (cnt < BYTE_BITS) && (state == ACCUM);
  assign fill_level = cnt;

  // Codeword alignment: clamp length, mask unused upper bits, and place the
  // codeword directly after the bits already held (valid bits left-justified).
  always_comb begin
    len_eff   = (code_len > MAX_LEN) ? MAX_LEN : code_len;
    code_ext  = BYTE_W'(code_bits);
    code_mask = BYTE_W'((9'(1) << len_eff) - 9'(1));
    code_m    = code_ext & code_mask;
    shamt     = CNT_W'(5'(ACC_W) - 5'(cnt) - 5'(len_eff));
    ins       = ACC_W'(code_m) << shamt;
  end

  // Handshake decode and next accumulator contents.
  always_comb begin
    accept     = code_valid && code_ready;
    slot_free  = !byte_valid || byte_ready;
    extract    = (cnt >= BYTE_BITS) && slot_free;
    flush_exit = (state == FLUSH) && (cnt < BYTE_BITS) && slot_free;
    pad_load   = flush_exit && (cnt != '0);
    acc_app    = accept ? (acc | ins) : acc;
    cnt_sum    = {1'b0, cnt} + (accept ? {1'b0, len_eff} : '0);
    acc_next   = acc_app;
    cnt_next   = CNT_W'(cnt_sum);
    if (extract) begin
      acc_next = acc_app << BYTE_W;
      cnt_next = CNT_W'(cnt_sum - 5'(BYTE_W));
    end else if (flush_exit) begin
      acc_next = '0;
      cnt_next = '0;
    end
  end

  // Control FSM, accumulator and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_last  <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      acc        <= acc_next;
      cnt        <= cnt_next;
      flush_done <= (state == DONE);

      if (extract) begin
        byte_data  <= acc[ACC_W-1 -: BYTE_W];
        byte_last  <= 1'b0;
        byte_valid <= 1'b1;
      end else if (pad_load) begin
        // Bits below the held count are already zero, giving the padding.
        byte_data  <= acc[ACC_W-1 -: BYTE_W];
        byte_last  <= 1'b1;
        byte_valid <= 1'b1;
      end else if (slot_free) begin
        byte_valid <= 1'b0;
      end

      case (state)
        ACCUM:   if (flush) state <= FLUSH;
        FLUSH:   if (flush_exit) state <= DONE;
        DONE:    state <= ACCUM;
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: per-cycle vector table plus
// hand-written backpressure and mid-stream reset sequences.
module tb_huffman_bit_packer;

  logic       clk;
  logic       rst_n;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] code_bits;
  logic [3:0] code_len;
  logic       flush;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       flush_done;
  logic [3:0] fill_level;

  huffman_bit_packer #(.CODE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .flush      (flush),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .flush_done (flush_done),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [7:0] bits;
    logic [3:0] len;
    logic       fl;
    logic       e_bv;
    logic [7:0] e_data;
    logic       e_last;
    logic [3:0] e_fill;
    logic       e_cr;
    logic       e_fd;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  int         sent;
  int         nbytes;
  bit         stall_seen;
  bit         done4;
  logic       acc_h;
  logic       take_h;
  logic [7:0] seen;

  function automatic vec_t mk(logic cv, logic [7:0] b, logic [3:0] l, logic fl,
                              logic bv, logic [7:0] d, logic la, logic [3:0] fi,
                              logic cr, logic fd);
    vec_t v;
    v.cv = cv; v.bits = b; v.len = l; v.fl = fl;
    v.e_bv = bv; v.e_data = d; v.e_last = la; v.e_fill = fi;
    v.e_cr = cr; v.e_fd = fd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b1; code_valid = 1'b0; code_bits = '0; code_len = '0;
    flush = 1'b0; byte_ready = 1'b1;

    //            cv  bits   len   fl  | bv  data   last fill   cr  fd
    // single byte 101 + 10011 -> B3
    vecs.push_back(mk(1, 8'h05, 4'd3,  0, 0, 8'h00, 0, 4'd3,  1, 0));
    vecs.push_back(mk(1, 8'h13, 4'd5,  0, 0, 8'h00, 0, 4'd8,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 1, 8'hB3, 0, 4'd0,  1, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 0));
    // straddle 110011 + 000111 -> CC, then flush -> 70 last
    vecs.push_back(mk(1, 8'h33, 4'd6,  0, 0, 8'h00, 0, 4'd6,  1, 0));
    vecs.push_back(mk(1, 8'h07, 4'd6,  0, 0, 8'h00, 0, 4'd12, 0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 1, 8'hCC, 0, 4'd4,  1, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  1, 0, 8'h00, 0, 4'd4,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 1, 8'h70, 1, 4'd0,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 0));
    // empty flush: no byte, one flush_done
    vecs.push_back(mk(0, 8'h00, 4'd0,  1, 0, 8'h00, 0, 4'd0,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 0));
    // flush together with codeword 11 -> C0 last
    vecs.push_back(mk(1, 8'h03, 4'd2,  1, 0, 8'h00, 0, 4'd2,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 1, 8'hC0, 1, 4'd0,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 0));
    // len 0, upper-bit masking, len clamp: 0 + 010 + A5 -> 2A, pad 0101 -> 50
    vecs.push_back(mk(1, 8'h00, 4'd1,  0, 0, 8'h00, 0, 4'd1,  1, 0));
    vecs.push_back(mk(1, 8'hFF, 4'd0,  0, 0, 8'h00, 0, 4'd1,  1, 0));
    vecs.push_back(mk(1, 8'hFA, 4'd3,  0, 0, 8'h00, 0, 4'd4,  1, 0));
    vecs.push_back(mk(1, 8'hA5, 4'd12, 0, 0, 8'h00, 0, 4'd12, 0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 1, 8'h2A, 0, 4'd4,  1, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  1, 0, 8'h00, 0, 4'd4,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 1, 8'h50, 1, 4'd0,  0, 0));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 1));
    vecs.push_back(mk(0, 8'h00, 4'd0,  0, 0, 8'h00, 0, 4'd0,  1, 0));

    // reset asserted mid-cycle, values must appear before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_last", byte_last, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_fill_level", fill_level, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_code_ready", code_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      code_valid = vecs[i].cv;
      code_bits  = vecs[i].bits;
      code_len   = vecs[i].len;
      flush      = vecs[i].fl;
      byte_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_byte_valid", i), byte_valid, vecs[i].e_bv);
      if (vecs[i].e_bv) begin
        check($sformatf("row%0d_byte_data", i), byte_data, vecs[i].e_data);
        check($sformatf("row%0d_byte_last", i), byte_last, vecs[i].e_last);
      end
      check($sformatf("row%0d_fill_level", i), fill_level, vecs[i].e_fill);
      check($sformatf("row%0d_code_ready", i), code_ready, vecs[i].e_cr);
      check($sformatf("row%0d_flush_done", i), flush_done, vecs[i].e_fd);
    end
    code_valid = 1'b0; flush = 1'b0;

    // backpressure: eight 111 codewords, consumer stalled for 10 cycles
    sent = 0; nbytes = 0; stall_seen = 0; done4 = 0;
    for (int cyc = 0; cyc < 60 && !done4; cyc++) begin
      code_valid = (sent < 8);
      code_bits  = 8'h07;
      code_len   = 4'd3;
      flush      = 1'b0;
      byte_ready = (cyc >= 10);
      if (byte_valid && !byte_ready) begin
        check("bp_hold_data", byte_data, 8'hFF);
        if (!code_ready && fill_level >= 4'd8) stall_seen = 1;
      end
      acc_h  = code_valid && code_ready;
      take_h = byte_valid && byte_ready;
      seen   = byte_data;
      @(posedge clk);
      #1;
      if (acc_h) sent++;
      if (take_h) begin
        nbytes++;
        check("bp_byte_data", seen, 8'hFF);
      end
      if (sent == 8 && byte_ready && !byte_valid && fill_level == 4'd0) done4 = 1;
    end
    code_valid = 1'b0;
    check("bp_stall_seen", stall_seen, 1);
    check("bp_byte_count", nbytes, 3);
    check("bp_sent", sent, 8);
    check("bp_fill_level", fill_level, 0);

    // reset mid-stream with a pending byte and 5 buffered bits
    byte_ready = 1'b0;
    code_valid = 1'b1; code_bits = 8'h3C; code_len = 4'd8;
    @(posedge clk); #1;
    code_valid = 1'b0;
    @(posedge clk); #1;
    check("rs_pending_valid", byte_valid, 1);
    code_valid = 1'b1; code_bits = 8'h16; code_len = 4'd5;
    @(posedge clk); #1;
    code_valid = 1'b0;
    check("rs_fill_before", fill_level, 5);
    #3 rst_n = 1'b0;
    #1;
    check("rs_byte_valid", byte_valid, 0);
    check("rs_byte_data", byte_data, 8'h00);
    check("rs_byte_last", byte_last, 0);
    check("rs_fill_level", fill_level, 0);
    check("rs_code_ready", code_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    byte_ready = 1'b1;
    code_valid = 1'b1; code_bits = 8'hA5; code_len = 4'd8;
    @(posedge clk); #1;
    code_valid = 1'b0;
    nbytes = 0; seen = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (byte_valid) begin
        nbytes++;
        seen = byte_data;
      end
      @(posedge clk); #1;
    end
    check("rs_byte_count", nbytes, 1);
    check("rs_byte_a5", seen, 8'hA5);
    check("rs_fill_after", fill_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
